// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - operand/result handshake bundle for the pipelined barrel shifter
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shamt;
  logic             dir;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

  modport master (
    output in_valid, in, shamt, dir, mode, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, shamt, dir, mode, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - log-depth pipelined shifter: logical, arithmetic and rotate, both directions
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_barrel_shifter_if.slave bus
);

  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input int               amt,
    input logic             left,
    input logic [1:0]       mode,
    input logic             fill
  );
    logic [WIDTH-1:0] r;
    if (left) begin
      r = d << amt;
      if (mode == MODE_ROTATE) r = r | (d >> (WIDTH - amt));
    end else begin
      r = d >> amt;
      if (mode == MODE_ROTATE)
        r = r | (d << (WIDTH - amt));
      else if (mode == MODE_ARITH && fill)
        r = r | ~({WIDTH{1'b1}} >> amt);
    end
    return r;
  endfunction

  // Index k is the input side of stage k; index SHW is the output register.
  logic [SHW:0][WIDTH-1:0] s_data;
  logic [SHW:0]            s_valid;
  logic [SHW-1:0][SHW-1:0] s_sh;
  logic [SHW-1:0]          s_dir;
  logic [SHW-1:0][1:0]     s_mode;
  logic [SHW-1:0]          s_fill;
  logic                    adv;

  // One global enable: the whole pipe freezes while a result waits downstream.
  assign adv          = ~s_valid[SHW] | bus.out_ready;
  assign bus.in_ready = adv;

  assign s_data[0]  = bus.in;
  assign s_valid[0] = bus.in_valid;
  assign s_sh[0]    = bus.shamt;
  assign s_dir[0]   = bus.dir;
  assign s_mode[0]  = bus.mode;
  assign s_fill[0]  = bus.in[WIDTH-1];

  genvar k;
  generate
    for (k = 0; k < SHW; k++) begin : g_stage
      localparam int AMT = 1 << k;
      logic [WIDTH-1:0] data_r;
      logic             valid_r;

      // Data only moves with a valid op, so out keeps its last result across bubbles.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_r <= 1'b0;
          data_r  <= '0;
        end else if (adv) begin
          valid_r <= s_valid[k];
          if (s_valid[k])
            data_r <= s_sh[k][0] ? shift_by(s_data[k], AMT, s_dir[k], s_mode[k], s_fill[k])
                                 : s_data[k];
        end
      end

      assign s_data[k+1]  = data_r;
      assign s_valid[k+1] = valid_r;

      if (k < SHW - 1) begin : g_ctl
        logic [SHW-1:0] sh_r;
        logic           dir_r;
        logic [1:0]     mode_r;
        logic           fill_r;

        // Shamt is consumed LSB-first, so each stage sees its own bit at position 0.
        always_ff @(posedge clk) begin
          if (adv && s_valid[k]) begin
            sh_r   <= s_sh[k] >> 1;
            dir_r  <= s_dir[k];
            mode_r <= s_mode[k];
            fill_r <= s_fill[k];
          end
        end

        assign s_sh[k+1]   = sh_r;
        assign s_dir[k+1]  = dir_r;
        assign s_mode[k+1] = mode_r;
        assign s_fill[k+1] = fill_r;
      end
    end
  endgenerate

  assign bus.out_valid = s_valid[SHW];
  assign bus.out       = s_data[SHW];

endmodule
